// File: rtl/usb_fs_tx.sv
// Full-speed USB transmitter: SYNC/PID/payload/CRC16/EOP serializer with NRZI
// encoding and bit stuffing, one line symbol per USB_CLOCK_MULT clocks.
module usb_fs_tx #(
  parameter int USB_CLOCK_MULT = 4
) (
  input  logic       clk_usb,
  input  logic       reset,
  input  logic       pkt_start,
  input  logic [3:0] pid,
  input  logic       tx_data_avail,
  input  logic [7:0] tx_data,
  output logic       tx_data_get,
  output logic       dp,
  output logic       dn,
  output logic       oe,
  output logic       busy,
  output logic       pkt_end
);

  localparam int PW = (USB_CLOCK_MULT > 1) ? $clog2(USB_CLOCK_MULT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] phase;
  logic [7:0]    sr, sr_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [2:0]    ones, ones_n;
  logic          stuffing, stuffing_n;
  logic [15:0]   crc, crc_n;
  logic [1:0]    eop_cnt, eop_cnt_n;
  logic [3:0]    pid_q;
  logic          dp_n, dn_n, oe_n, busy_n, end_n;
  logic          get, fetch, boundary, accept;

  assign boundary    = (phase == PW'(USB_CLOCK_MULT - 1));
  // The release cycle (pkt_end high) is still IDLE but must not start a packet.
  assign accept      = (state == S_IDLE) && pkt_start && !pkt_end;
  assign tx_data_get = get & ~reset;

  // NOTE: every variable gets a default before any branch, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    sr_n       = sr;
    bit_cnt_n  = bit_cnt;
    ones_n     = ones;
    stuffing_n = stuffing;
    crc_n      = crc;
    eop_cnt_n  = eop_cnt;
    dp_n       = dp;
    dn_n       = dn;
    oe_n       = oe;
    busy_n     = busy;
    end_n      = 1'b0;
    get        = 1'b0;
    fetch      = 1'b0;

    if (state == S_IDLE) begin
      if (accept) begin
        state_n    = S_SYNC;
        sr_n       = 8'h80;
        bit_cnt_n  = 3'd0;
        ones_n     = 3'd0;
        stuffing_n = 1'b0;
        crc_n      = 16'hFFFF;
        eop_cnt_n  = 2'd0;
        busy_n     = 1'b1;
        oe_n       = 1'b1;
        dp_n       = 1'b0;  // first SYNC bit is a 0: J -> K
        dn_n       = 1'b1;
      end
    end else if (boundary) begin
      stuffing_n = 1'b0;
      // A stuff bit does not advance the bit/byte position.
      if (!stuffing) begin
        if (state == S_EOP) begin
          if (eop_cnt == 2'd2) begin
            state_n = S_IDLE;
            oe_n    = 1'b0;
            dp_n    = 1'b1;
            dn_n    = 1'b0;
            busy_n  = 1'b0;
            end_n   = 1'b1;
          end else begin
            eop_cnt_n = eop_cnt + 2'd1;
          end
        end else if (bit_cnt != 3'd7) begin
          sr_n      = {1'b0, sr[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
        end else begin
          bit_cnt_n = 3'd0;
          case (state)
            S_SYNC: begin
              sr_n    = {~pid_q, pid_q};
              state_n = S_PID;
            end
            S_PID: begin
              fetch = (pid_q[1:0] == 2'b11);
              if (!fetch) state_n = S_EOP;
            end
            S_DATA: fetch = 1'b1;
            S_CRC_LO: begin
              sr_n    = ~crc[15:8];
              state_n = S_CRC_HI;
            end
            S_CRC_HI: state_n = S_EOP;
            default: ;
          endcase
          if (fetch) begin
            if (tx_data_avail) begin
              get     = 1'b1;
              sr_n    = tx_data;
              state_n = S_DATA;
            end else begin
              sr_n    = ~crc[7:0];
              state_n = S_CRC_LO;
            end
          end
        end
      end

      if (state_n != S_IDLE) begin
        if (!stuffing && state != S_EOP && ones == 3'd6) begin
          stuffing_n = 1'b1;
          ones_n     = 3'd0;
          dp_n       = ~dp;
          dn_n       = dp;
        end else if (state_n == S_EOP) begin
          dp_n = (eop_cnt_n == 2'd2);
          dn_n = 1'b0;
        end else begin
          if (sr_n[0]) begin
            ones_n = ones + 3'd1;
          end else begin
            ones_n = 3'd0;
            dp_n   = ~dp;
            dn_n   = dp;
          end
          // Reflected form of polynomial 0x8005, fed LSB first.
          if (state_n == S_DATA)
            crc_n = {1'b0, crc[15:1]} ^ ((crc[0] ^ sr_n[0]) ? 16'hA001 : 16'h0000);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk_usb) begin
    if (reset) begin
      state    <= S_IDLE;
      phase    <= '0;
      sr       <= 8'h00;
      bit_cnt  <= 3'd0;
      ones     <= 3'd0;
      stuffing <= 1'b0;
      crc      <= 16'hFFFF;
      eop_cnt  <= 2'd0;
      pid_q    <= 4'h0;
      dp       <= 1'b1;
      dn       <= 1'b0;
      oe       <= 1'b0;
      busy     <= 1'b0;
      pkt_end  <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= (state == S_IDLE || boundary) ? '0 : phase + PW'(1);
      sr       <= sr_n;
      bit_cnt  <= bit_cnt_n;
      ones     <= ones_n;
      stuffing <= stuffing_n;
      crc      <= crc_n;
      eop_cnt  <= eop_cnt_n;
      if (accept) pid_q <= pid;
      dp       <= dp_n;
      dn       <= dn_n;
      oe       <= oe_n;
      busy     <= busy_n;
      pkt_end  <= end_n;
    end
  end

endmodule

// File: doc/usb_fs_tx.md
# usb_fs_tx

Full-speed USB transmit path: serializes a packet (SYNC, PID, optional data payload, CRC16, EOP) onto the D+/D- pair with NRZI encoding and bit stuffing. Runs entirely in the 48/60 MHz USB clock domain and drives the pad output-enable. Sits alongside `usb_fs_rx` under the USB PHY wrapper. The protocol engine starts each packet with `pkt_start` and supplies payload bytes through a get/avail handshake.

## Interface
- `USB_CLOCK_MULT`, 4, clocks per bit (4 -> 48 MHz, 5 -> 60 MHz)
- `clk_usb`  in  1  USB bit-recovery clock; the only clock
- `reset`  in  1  synchronous, active-high
- `pkt_start`  in  1  one-cycle request to send a packet; sampled only in IDLE
- `pid`  in  4  PID nibble; sampled with `pkt_start`
- `tx_data_avail`  in  1  a payload byte is valid on `tx_data`
- `tx_data`  in  8  payload byte, LSB sent first
- `tx_data_get`  out  1  one-cycle pulse: `tx_data` consumed this cycle
- `dp`, `dn`  out  1 each  line drive
- `oe`  out  1  pad output enable
- `busy`  out  1  high from the cycle after an accepted `pkt_start` until `pkt_end`
- `pkt_end`  out  1  one-cycle pulse on the cycle `oe` falls

## Operation
- Reset values: `oe`=0, `dp`=1, `dn`=0 (J), `tx_data_get`=0, `pkt_end`=0, `busy`=0, state IDLE. Reset mid-packet aborts at once: `oe`=0 on the next cycle and no `pkt_end` pulse.
- States: IDLE -> SYNC -> PID -> (DATA -> CRC_LO -> CRC_HI) -> EOP -> IDLE.
- PID type:
  - Data PIDs (`pid[1:0]`==2'b11) take the DATA path.
  - All other PIDs go from PID straight to EOP.
- SYNC: byte 0x80, LSB first.
- PID: byte {~pid, pid}, LSB first.
- Byte fetch (DATA path):
  - A fetch occurs on the last clock of bit 7 of the PID byte and of each data byte.
  - If `tx_data_avail`=1: load `tx_data` and pulse `tx_data_get`, then stay in DATA.
  - If `tx_data_avail`=0: go to CRC_LO; no get pulse.
- CRC16:
  - Polynomial 0x8005, register initialized to 0xFFFF at `pkt_start`.
  - Updated on each payload data bit only; SYNC, PID and stuff bits are excluded.
  - Transmitted complemented, LSB first: low byte, then high byte.
  - Zero-length packet sends CRC bytes 0x00, 0x00.
- NRZI: line starts at J. A 0 bit toggles J<->K; a 1 bit holds the line.
- Bit stuffing:
  - A ones counter is cleared at `pkt_start` and counts from the SYNC field through the last CRC bit.
  - After 6 consecutive 1s, one 0 (a toggle) is inserted before the next bit.
  - The stuff bit does not advance the bit or byte count and does not update the CRC.
  - A stuff bit owed after the final PID or CRC bit is sent before EOP.
- EOP: 2 bit times of SE0 (`dp`=`dn`=0), then 1 bit time of J with `oe`=1. After that, `oe`=0 and the FSM returns to IDLE.
- `pkt_start` while busy, or in its release cycle, is ignored.

## Timing
- Each line symbol is held exactly `USB_CLOCK_MULT` cycles. A bit-phase counter runs 0..MULT-1 and is cleared on an accepted `pkt_start`.
- Start: `pkt_start` at cycle N -> `oe`=1 with the first SYNC bit (K: `dp`=0, `dn`=1) at N+1.
- End: `oe` falls and `pkt_end` pulses on the cycle after the last EOP J clock. `busy` falls in that same cycle.
- Handshake packet with no stuffing occupies 19 bit times (8 SYNC + 8 PID + 3 EOP) = 19·MULT cycles of `oe`=1.
- `tx_data_get` rate: at most one pulse per 8·MULT cycles. `tx_data` needs to be valid only in the pulse cycle.
- Next packet: `pkt_start` is accepted one cycle after `pkt_end`.

## Test plan
- ACK, MULT=4: `pid`=0x2 -> line K J K J K J K K, then PID 0xD2 NRZI symbols, then SE0 SE0 J. `oe` high for exactly 76 cycles, one `pkt_end`, zero `tx_data_get`.
- DATA1 zero-length: `pid`=0xB, `tx_data_avail`=0 -> PID byte 0x4B, CRC bytes 0x00 0x00, EOP. Loopback into `usb_fs_rx` (both clocks tied) reports `valid_packet`=1 and `pid`=0xB.
- DATA0 payload 0x00,0x01,0x02,0x03 -> exactly 4 `tx_data_get` pulses 32 cycles apart. Loopback `rx_data` yields the 4 bytes then CRC, with `valid_packet`=1.
- Bit stuffing: DATA0 with payload 0xFF,0xFF -> bench counts one stuff bit after each run of 6 ones. Total `oe` cycles equal (unstuffed bits + stuff bits)·4. Loopback reports `valid_packet`=1.
- `pkt_start` pulsed mid-packet -> ignored: same waveform, single `pkt_end`.
- `reset` asserted during DATA -> `oe`=0, `dp`/`dn`=J next cycle, no `pkt_end`. A following `pkt_start` produces a correct packet.
- MULT=5: repeat the ACK case -> `oe` high for 95 cycles.
